// File: rtl/calib_if.sv
// calib_if: sample/LED bundle between the blob tracker front end and calib_ctrl.
//   master : drives start, valid, x, y, dir_leds; receives leds, calibrated, cal_x, cal_y
//   slave  : calib_ctrl side (mirror of master)
interface calib_if;
    logic       start;       // one-cycle pulse: begin/restart calibration
    logic       valid;       // one-cycle strobe: x/y valid
    logic [9:0] x;           // blob column
    logic [9:0] y;           // blob row, 1023 = no blob
    logic [4:0] dir_leds;    // direction LED levels, bit0=LED1
    logic [4:0] leds;        // board LEDs, bit0=LED1
    logic       calibrated;  // high while locked
    logic [9:0] cal_x;       // latched calibration column
    logic [9:0] cal_y;       // latched calibration row

    modport master (
        output start, valid, x, y, dir_leds,
        input  leds, calibrated, cal_x, cal_y
    );

    modport slave (
        input  start, valid, x, y, dir_leds,
        output leds, calibrated, cal_x, cal_y
    );
endinterface

// File: rtl/calib_ctrl.sv
// calib_ctrl: calibration sequencer for the IR camera blob tracker.
// Guides the user into the centre window, requires HOLD_SAMPLES consecutive
// in-window samples to lock, latches the locking sample as the calibration
// point, and drops lock after LOST_SAMPLES consecutive no-blob samples.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : calib_if.slave (start/valid/x/y/dir_leds in; leds/calibrated/cal_x/cal_y out)
// All outputs are registered.
module calib_ctrl #(
    parameter int unsigned MID_X         = 512,
    parameter int unsigned MID_Y         = 384,
    parameter int unsigned CENT_D        = 250,
    parameter int unsigned HOLD_SAMPLES  = 60,
    parameter int unsigned LOST_SAMPLES  = 8,
    parameter int unsigned BLINK_SAMPLES = 8
) (
    input logic     clk,
    input logic     reset,
    calib_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEEK, HOLD, LOCKED} state_e;

    localparam logic [10:0] MX     = 11'(MID_X);
    localparam logic [10:0] MY     = 11'(MID_Y);
    localparam logic [10:0] CD     = 11'(CENT_D);
    localparam logic [10:0] HI_X   = 11'(MID_X + CENT_D);
    localparam logic [10:0] HI_Y   = 11'(MID_Y + CENT_D);
    localparam logic [9:0]  HOLD_N = 10'(HOLD_SAMPLES);
    localparam logic [7:0]  LOST_N = 8'(LOST_SAMPLES);
    localparam logic [7:0]  BLNK_N = 8'(BLINK_SAMPLES);

    state_e     state_q, state_d;
    logic [9:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] lost_cnt_q, lost_cnt_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_q, blink_d;
    logic [4:0] leds_q, leds_d;
    logic       cal_q, cal_d;
    logic [9:0] cal_x_q, cal_x_d;
    logic [9:0] cal_y_q, cal_y_d;

    logic       present, in_win;
    logic [9:0] hold_nxt;
    logic [7:0] lost_nxt, blink_nxt;
    logic [10:0] x11, y11;

    assign x11     = {1'b0, bus.x};
    assign y11     = {1'b0, bus.y};
    assign present = bus.valid & (bus.y != 10'h3FF);
    // The lower bound is tested as x + D > MID so nothing wraps when MID < D.
    assign in_win  = present
                   & ((x11 + CD) > MX) & (x11 < HI_X)
                   & ((y11 + CD) > MY) & (y11 < HI_Y);

    // Saturating increments.
    assign hold_nxt  = (hold_cnt_q  == HOLD_N) ? hold_cnt_q  : hold_cnt_q  + 10'd1;
    assign lost_nxt  = (lost_cnt_q  == LOST_N) ? lost_cnt_q  : lost_cnt_q  + 8'd1;
    assign blink_nxt = (blink_cnt_q == BLNK_N) ? blink_cnt_q : blink_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        cal_x_d     = cal_x_q;
        cal_y_d     = cal_y_q;

        if (bus.start) begin
            // start beats a coincident sample; cal_x/cal_y are kept.
            state_d     = SEEK;
            hold_cnt_d  = '0;
            lost_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (bus.valid) begin
            case (state_q)
                SEEK: begin
                    if (in_win) begin
                        if (HOLD_N == 10'd1) begin
                            // Entering sample already satisfies the hold count.
                            state_d = LOCKED;
                            cal_x_d = bus.x;
                            cal_y_d = bus.y;
                        end else begin
                            state_d     = HOLD;
                            hold_cnt_d  = 10'd1;
                            blink_cnt_d = '0;
                            blink_d     = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (in_win) begin
                        if (hold_nxt == HOLD_N) begin
                            state_d     = LOCKED;
                            cal_x_d     = bus.x;
                            cal_y_d     = bus.y;
                            hold_cnt_d  = '0;
                            blink_cnt_d = '0;
                            blink_d     = 1'b0;
                        end else begin
                            hold_cnt_d = hold_nxt;
                            if (blink_nxt == BLNK_N) begin
                                blink_d     = ~blink_q;
                                blink_cnt_d = '0;
                            end else begin
                                blink_cnt_d = blink_nxt;
                            end
                        end
                    end else begin
                        state_d     = SEEK;
                        hold_cnt_d  = '0;
                        blink_cnt_d = '0;
                        blink_d     = 1'b0;
                    end
                end
                LOCKED: begin
                    if (present) begin
                        lost_cnt_d = '0;
                    end else if (lost_nxt == LOST_N) begin
                        state_d    = SEEK;
                        lost_cnt_d = '0;
                    end else begin
                        lost_cnt_d = lost_nxt;
                    end
                end
                default: ;  // IDLE ignores samples until start
            endcase
        end

        // LED mux keyed on the next state so leds land with the state change.
        case (state_d)
            SEEK:    leds_d = bus.dir_leds;
            HOLD:    leds_d = {blink_d, 4'b0000};
            LOCKED:  leds_d = 5'b10000;
            default: leds_d = 5'b00000;
        endcase
        cal_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            lost_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            leds_q      <= '0;
            cal_q       <= 1'b0;
            cal_x_q     <= '0;
            cal_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            leds_q      <= leds_d;
            cal_q       <= cal_d;
            cal_x_q     <= cal_x_d;
            cal_y_q     <= cal_y_d;
        end
    end

    assign bus.leds       = leds_q;
    assign bus.calibrated = cal_q;
    assign bus.cal_x      = cal_x_q;
    assign bus.cal_y      = cal_y_q;
endmodule

// File: tb/tb_calib_ctrl.sv
// tb_calib_ctrl: directed, table-driven bench for calib_ctrl (default parameters).
module tb_calib_ctrl;
    logic clk;
    logic reset;
    calib_if bus ();

    calib_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       st;
        logic       v;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] dir;
        logic [4:0] leds;
        logic       cal;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] el, input logic ec,
                           input logic [9:0] ex, input logic [9:0] ey);
        chk({tag, ".leds"},       {27'd0, bus.leds},       {27'd0, el});
        chk({tag, ".calibrated"}, {31'd0, bus.calibrated}, {31'd0, ec});
        chk({tag, ".cal_x"},      {22'd0, bus.cal_x},      {22'd0, ex});
        chk({tag, ".cal_y"},      {22'd0, bus.cal_y},      {22'd0, ey});
    endtask

    // One clock: inputs driven after negedge, outputs sampled 1 after posedge.
    task automatic cyc(input logic st, input logic v, input logic [9:0] xx,
                       input logic [9:0] yy, input logic [4:0] dd);
        @(negedge clk);
        bus.start    = st;
        bus.valid    = v;
        bus.x        = xx;
        bus.y        = yy;
        bus.dir_leds = dd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic [4:0] dd);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 10'd0, 10'd0, dd);
    endtask

    initial begin
        logic exp_blink;

        //          st    v     x        y         dir       leds      cal
        tbl[0]  = '{1'b0, 1'b1, 10'd512, 10'd384,  5'b00101, 5'b00000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 10'd512, 10'd384,  5'b00101, 5'b00000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 10'd0,   10'd0,    5'b00101, 5'b00101, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 10'd0,   10'd0,    5'b01010, 5'b01010, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 10'd262, 10'd384,  5'b01010, 5'b01010, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 10'd512, 10'd134,  5'b00011, 5'b00011, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 10'd512, 10'd1023, 5'b00001, 5'b00001, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 10'd263, 10'd384,  5'b00001, 5'b10000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 10'd0,   10'd0,    5'b00001, 5'b10000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 10'd300, 10'd200,  5'b00001, 5'b10000, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 10'd763, 10'd384,  5'b00100, 5'b00100, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 10'd762, 10'd384,  5'b00100, 5'b00100, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 10'd761, 10'd384,  5'b00100, 5'b10000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 10'd512, 10'd634,  5'b00010, 5'b00010, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 10'd512, 10'd633,  5'b00010, 5'b10000, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 10'd512, 10'd1023, 5'b11000, 5'b11000, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 10'd0,   10'd0,    5'b10001, 5'b10001, 1'b0};

        bus.start    = 1'b0;
        bus.valid    = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.dir_leds = '0;

        // Reset for two cycles.
        reset = 1'b1;
        idle(2, 5'b00000);
        chk_out("reset", 5'b00000, 1'b0, 10'd0, 10'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle ignore, window boundaries, leds pass-through.
        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].dir);
            chk_out($sformatf("vec%0d", i), tbl[i].leds, tbl[i].cal, 10'd0, 10'd0);
            if (i == 10) chk("vec10.hold_cnt", {22'd0, dut.hold_cnt_q}, 32'd0);
        end

        // Lock: 60 samples spaced 3 cycles apart, LED5 toggles every 8.
        cyc(1'b1, 1'b0, 10'd0, 10'd0, 5'b00111);
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b0, 1'b1, 10'd500, 10'd400, 5'b00111);
            if (i < 60) begin
                exp_blink = ~(1'(((i - 1) / 8) & 1));
                chk_out($sformatf("hold%0d", i), {exp_blink, 4'b0000}, 1'b0, 10'd0, 10'd0);
                idle(2, 5'b00111);
            end else begin
                chk_out("lock", 5'b10000, 1'b1, 10'd500, 10'd400);
            end
        end

        // Tracking loss: 7 no-blob, 1 blob, 8 no-blob.
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b1, 10'd0, 10'd1023, 5'b01001);
            chk_out($sformatf("lostA%0d", i), 5'b10000, 1'b1, 10'd500, 10'd400);
        end
        cyc(1'b0, 1'b1, 10'd100, 10'd100, 5'b01001);
        chk_out("blob", 5'b10000, 1'b1, 10'd500, 10'd400);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 10'd0, 10'd1023, 5'b01001);
            if (i < 8) chk_out($sformatf("lostB%0d", i), 5'b10000, 1'b1, 10'd500, 10'd400);
            else       chk_out("unlock", 5'b01001, 1'b0, 10'd500, 10'd400);
        end
        idle(1, 5'b00110);
        chk_out("seek_follow", 5'b00110, 1'b0, 10'd500, 10'd400);

        // Start colliding with an in-window sample in HOLD at hold_cnt=30.
        cyc(1'b1, 1'b0, 10'd0, 10'd0, 5'b00110);
        for (int i = 1; i <= 30; i++) cyc(1'b0, 1'b1, 10'd512, 10'd384, 5'b00110);
        chk("hold30.hold_cnt", {22'd0, dut.hold_cnt_q}, 32'd30);
        chk_out("hold30", 5'b00000, 1'b0, 10'd500, 10'd400);  // toggled at 9,17,25
        cyc(1'b1, 1'b1, 10'd512, 10'd384, 5'b00110);
        chk("collide.hold_cnt", {22'd0, dut.hold_cnt_q}, 32'd0);
        chk_out("collide", 5'b00110, 1'b0, 10'd500, 10'd400);
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b0, 1'b1, 10'd401, 10'd301, 5'b00110);
            if (i == 59) chk_out("relock59", 5'b00000, 1'b0, 10'd500, 10'd400);
        end
        chk_out("relock", 5'b10000, 1'b1, 10'd401, 10'd301);

        // Reset while LOCKED together with a valid sample.
        @(negedge clk);
        reset     = 1'b1;
        bus.valid = 1'b1;
        bus.x     = 10'd512;
        bus.y     = 10'd384;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.valid = 1'b0;
        chk_out("midreset", 5'b00000, 1'b0, 10'd0, 10'd0);
        chk("midreset.hold_cnt", {22'd0, dut.hold_cnt_q}, 32'd0);
        cyc(1'b0, 1'b1, 10'd512, 10'd384, 5'b11111);
        chk_out("post_reset_idle", 5'b00000, 1'b0, 10'd0, 10'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
